instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 16, meaning number of program words (fixed power of two; PC width 4).
REQ-002 SHALL have parameter IW, default 16, meaning instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load_en  input  1  program-write strobe.
REQ-006 SHALL have port load_addr  input  4  program word index.
REQ-007 SHALL have port load_data  input  16  program word.
REQ-008 SHALL have port start  input  1  single-cycle run request.
REQ-009 SHALL have port issue_ready  input  1  datapath accepts current issue.
REQ-010 SHALL have port zero  input  1  datapath zero flag.
REQ-011 SHALL have port issue_valid  output  1  opcode/operand fields valid.
REQ-012 SHALL have port opcode  output  3  issued opcode.
REQ-013 SHALL have port reg1, reg2  output  4 each  register operand addresses.
REQ-014 SHALL have port read_address, write_address  output  4 each  memory addresses (both equal the instruction addr field).
REQ-015 SHALL have port busy  output  1  high in any state except IDLE/HALTED.
REQ-016 SHALL have port done  output  1  one-cycle pulse on entry to HALTED.
REQ-017 SHALL have port pc  output  4  current program counter.
REQ-018 SHALL have port instr_count  output  8  issued-instruction count.

Function
REQ-019 SHALL decode words as [15:13] opcode, [12:9] reg1, [8:5] reg2, [4:1] addr, [0] ignored.
REQ-020 SHALL implement FSM IDLE, FETCH, ISSUE, BRWAIT, HALTED.
REQ-021 SHALL write program memory on load_en only in IDLE or HALTED; load_en in other states ignored.
REQ-022 SHALL, in IDLE/HALTED with start=1, clear pc and instr_count and go to FETCH next cycle; start in other states ignored.
REQ-023 SHALL, in FETCH, register mem[pc] into the output fields and go to ISSUE; issue_valid rises the cycle ISSUE is entered (start-to-valid latency 2 cycles).
REQ-024 SHALL hold issue_valid and all fields stable in ISSUE until issue_ready=1; transfer occurs on a cycle with both high.
REQ-025 SHALL, on transfer of an ordinary opcode (000-101), increment instr_count (saturating at 255), pc <= pc+1 with 15->0 wrap, go to FETCH.
REQ-026 SHALL, on transfer of opcode 110 (BRZ), increment instr_count and go to BRWAIT; issue_valid low in BRWAIT.
REQ-027 SHALL, in BRWAIT, sample zero once: zero=1 -> pc <= addr, zero=0 -> pc <= pc+1 (wrap); then FETCH.
REQ-028 SHALL, on transfer of opcode 111 (HALT), not increment instr_count, hold pc, go to HALTED and pulse done for exactly one cycle.
REQ-029 SHALL keep issue_valid low in IDLE, FETCH, BRWAIT, HALTED.
REQ-030 SHALL, when load_en and start coincide in IDLE/HALTED, perform the write and the start in the same cycle; the write lands before the first FETCH.

Reset
REQ-031 SHALL, on rst=1 at any time (including mid-ISSUE), immediately force state IDLE, pc=0, instr_count=0, issue_valid=0, done=0, busy=0, opcode/reg1/reg2/read_address/write_address=0.
REQ-032 SHALL NOT clear program memory on reset; contents persist across rst.

Verification
REQ-033 SHALL cover: load words 0..2 = opcode 001/010/111, start, issue_ready=1 -> three valids at cycles 2,4,6 after start, instr_count=2, done pulse, pc=2.
REQ-034 SHALL cover: issue_ready held 0 for 5 cycles in ISSUE -> issue_valid and fields constant all 5 cycles, pc unchanged.
REQ-035 SHALL cover: word0 = BRZ addr=5, zero=1 in BRWAIT -> next fetch pc=5; repeat with zero=0 -> pc=1.
REQ-036 SHALL cover: 16 non-HALT words, run 17 transfers -> pc wraps 15->0, word0 reissued; 300 transfers -> instr_count=255.
REQ-037 SHALL cover: rst asserted mid-ISSUE -> outputs zero same cycle; restart re-runs unchanged program from pc=0.
REQ-038 SHALL cover: load_en during busy to addr 1 -> memory word 1 unchanged on next run.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Small program sequencer. It holds a 16-word program memory that is loaded
// while the sequencer is idle or halted. It fetches words in order and issues
// their decoded fields to a datapath with a valid/ready handshake. It also
// supports a branch-if-zero instruction and a halt instruction.
//
// Instruction word layout:
//   [15:13] opcode
//   [12:9]  reg1
//   [8:5]   reg2
//   [4:1]   addr
//   [0]     unused
//
// Opcodes:
//   000-101  ordinary, advance to pc+1
//   110      BRZ: after issue, branch to addr if datapath zero flag is set
//   111      HALT: stop, pulse done
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   load_en/load_addr/load_data     program memory write port
//   start                           run request (from IDLE or HALTED)
//   issue_ready                     datapath accepts the current issue
//   zero                            datapath zero flag, sampled in BRWAIT
//   issue_valid                     decoded fields below are valid
//   opcode, reg1, reg2              decoded instruction fields
//   read_address, write_address     both carry the addr field
//   busy                            running (FETCH/ISSUE/BRWAIT)
//   done                            one-cycle pulse on entering HALTED
//   pc                              current program counter
//   instr_count                     saturating count of issued instructions
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int IW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [3:0]    load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic          issue_ready,
    input  logic          zero,
    output logic          issue_valid,
    output logic [2:0]    opcode,
    output logic [3:0]    reg1,
    output logic [3:0]    reg2,
    output logic [3:0]    read_address,
    output logic [3:0]    write_address,
    output logic          busy,
    output logic          done,
    output logic [3:0]    pc,
    output logic [7:0]    instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        BRWAIT = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [2:0] OP_BRZ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [7:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  reg1_q, reg1_d;
    logic [3:0]  reg2_q, reg2_d;
    logic [3:0]  addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [IW-1:0] mem_q [PROG_DEPTH];

    logic loadAllowed;
    assign loadAllowed = (state_q == IDLE) || (state_q == HALTED);

    // Program memory has no reset so a loaded program survives rst.
    // Writes are accepted only while not running. A write that coincides
    // with start lands at the same edge that enters FETCH, so the first
    // fetch already sees it.
    always_ff @(posedge clk) begin
        if (load_en && loadAllowed) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Next-state logic for the sequencer FSM and all registered outputs.
    // In BRWAIT the pc still points at the BRZ word, so pc+1 there is the
    // fall-through address.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        valid_d = valid_q;
        op_d    = op_q;
        reg1_d  = reg1_q;
        reg2_d  = reg2_q;
        addr_d  = addr_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d    = 4'd0;
                    count_d = 8'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                op_d    = mem_q[pc_q][15:13];
                reg1_d  = mem_q[pc_q][12:9];
                reg2_d  = mem_q[pc_q][8:5];
                addr_d  = mem_q[pc_q][4:1];
                valid_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (issue_ready) begin
                    valid_d = 1'b0;
                    if (op_q == OP_HALT) begin
                        state_d = HALTED;
                        done_d  = 1'b1;
                    end else begin
                        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                        if (op_q == OP_BRZ) begin
                            state_d = BRWAIT;
                        end else begin
                            pc_d    = pc_q + 4'd1;
                            state_d = FETCH;
                        end
                    end
                end
            end
            BRWAIT: begin
                pc_d    = zero ? addr_q : pc_q + 4'd1;
                state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == FETCH) || (state_d == ISSUE) || (state_d == BRWAIT);
    end

    // State and output registers. Reset clears every output immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= 4'd0;
            count_q <= 8'd0;
            valid_q <= 1'b0;
            op_q    <= 3'd0;
            reg1_q  <= 4'd0;
            reg2_q  <= 4'd0;
            addr_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign issue_valid   = valid_q;
    assign opcode        = op_q;
    assign reg1          = reg1_q;
    assign reg2          = reg2_q;
    assign read_address  = addr_q;
    assign write_address = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pc            = pc_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed sequence of program runs against instr_sequencer. Programs and
// handshake timing are randomized. Each run is followed by a
// transaction-level reference model. The model keeps the program, the
// program counter and the instruction count. It also tracks how many cycles
// remain until the next issue should appear.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        loadEn;
    logic [3:0]  loadAddr;
    logic [15:0] loadData;
    logic        start;
    logic        issueReady;
    logic        zero;
    logic        issueValid;
    logic [2:0]  opcode;
    logic [3:0]  reg1;
    logic [3:0]  reg2;
    logic [3:0]  readAddress;
    logic [3:0]  writeAddress;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [7:0]  instrCount;

    int compareCount = 0;
    int failCount    = 0;

    logic [15:0] modelMem [16];
    int          modelPc;
    int          modelCount;

    instr_sequencer #(.PROG_DEPTH(16), .IW(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_en       (loadEn),
        .load_addr     (loadAddr),
        .load_data     (loadData),
        .start         (start),
        .issue_ready   (issueReady),
        .zero          (zero),
        .issue_valid   (issueValid),
        .opcode        (opcode),
        .reg1          (reg1),
        .reg2          (reg2),
        .read_address  (readAddress),
        .write_address (writeAddress),
        .busy          (busy),
        .done          (done),
        .pc            (pc),
        .instr_count   (instrCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic le, input logic [3:0] addr,
                                 input logic [15:0] data, input logic st,
                                 input logic rdy);
        loadEn     = le;
        loadAddr   = addr;
        loadData   = data;
        start      = st;
        issueReady = rdy;
        tick();
        loadEn = 1'b0;
        start  = 1'b0;
    endtask

    function automatic logic [15:0] makeWord(input logic [2:0] op);
        return {op, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom)};
    endfunction

    task automatic loadWord(input logic [3:0] addr, input logic [15:0] data,
                            input bit expectWrite);
        applyStimulus(1'b1, addr, data, 1'b0, 1'b0);
        if (expectWrite) modelMem[addr] = data;
    endtask

    task automatic startRun();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
        modelPc    = 0;
        modelCount = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(issueValid), 0);
        checkOutput({tag, "_opcode"}, 32'(opcode), 0);
        checkOutput({tag, "_reg1"}, 32'(reg1), 0);
        checkOutput({tag, "_reg2"}, 32'(reg2), 0);
        checkOutput({tag, "_rdaddr"}, 32'(readAddress), 0);
        checkOutput({tag, "_wraddr"}, 32'(writeAddress), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_pc"}, 32'(pc), 0);
        checkOutput({tag, "_count"}, 32'(instrCount), 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Follows a run that has just been started (DUT now in FETCH). Issue
    // appears 1 cycle later, 2 cycles after an ordinary transfer and 3 after
    // BRZ. zeroMode: 0/1 force zero in the branch cycle, 2 random.
    task automatic runProgram(input int maxTransfers, input int readyPct,
                              input int zeroMode, input int cycleBudget,
                              input bit expectHalt, output int transfers);
        int          gap;
        int          cycles;
        int          op;
        bit          branchPending;
        bit          halted;
        logic [15:0] w;
        logic        rdy;
        logic        z;
        gap           = 1;
        cycles        = 0;
        branchPending = 1'b0;
        halted        = 1'b0;
        transfers     = 0;
        while (!halted && transfers < maxTransfers && cycles < cycleBudget) begin
            w   = modelMem[modelPc];
            op  = int'(w[15:13]);
            rdy = 1'b0;
            z   = 1'($urandom_range(1));
            checkOutput("run_done_low", 32'(done), 0);
            checkOutput("run_busy", 32'(busy), 1);
            checkOutput("run_pc", 32'(pc), modelPc);
            checkOutput("run_count", 32'(instrCount), modelCount);
            if (gap == 0) begin
                checkOutput("issue_valid_high", 32'(issueValid), 1);
                checkOutput("opcode", 32'(opcode), 32'(w[15:13]));
                checkOutput("reg1", 32'(reg1), 32'(w[12:9]));
                checkOutput("reg2", 32'(reg2), 32'(w[8:5]));
                checkOutput("read_address", 32'(readAddress), 32'(w[4:1]));
                checkOutput("write_address", 32'(writeAddress), 32'(w[4:1]));
                rdy = ($urandom_range(99) < 32'(readyPct));
                if (rdy) begin
                    transfers++;
                    if (op == 7) begin
                        halted = 1'b1;
                    end else begin
                        if (modelCount < 255) modelCount++;
                        if (op == 6) begin
                            branchPending = 1'b1;
                            gap = 3;
                        end else begin
                            modelPc = (modelPc + 1) % 16;
                            gap = 2;
                        end
                    end
                end
            end else begin
                checkOutput("issue_valid_low", 32'(issueValid), 0);
                if (branchPending && gap == 2) begin
                    if (zeroMode < 2) z = zeroMode[0];
                    modelPc = z ? int'(w[4:1]) : (modelPc + 1) % 16;
                    branchPending = 1'b0;
                end
            end
            zero       = z;
            issueReady = rdy;
            tick();
            if (gap > 0) gap--;
            cycles++;
        end
        issueReady = 1'b0;
        zero       = 1'b0;
        if (halted) begin
            checkOutput("halt_done_pulse", 32'(done), 1);
            checkOutput("halt_busy", 32'(busy), 0);
            checkOutput("halt_valid", 32'(issueValid), 0);
            checkOutput("halt_pc", 32'(pc), modelPc);
            checkOutput("halt_count", 32'(instrCount), modelCount);
            tick();
            checkOutput("halt_done_drop", 32'(done), 0);
        end else if (expectHalt) begin
            compareCount++;
            failCount++;
            $error("[TB] FAIL halt_timeout: observed=no halt within %0d cycles expected=halt",
                   cycleBudget);
        end
    endtask

    initial begin
        int          t;
        logic [15:0] w;
        rst        = 1'b1;
        loadEn     = 1'b0;
        loadAddr   = 4'd0;
        loadData   = 16'd0;
        start      = 1'b0;
        issueReady = 1'b0;
        zero       = 1'b0;
        modelPc    = 0;
        modelCount = 0;

        // Reset state, while held and after release.
        tick();
        tick();
        checkResetState("reset_held");
        rst = 1'b0;
        tick();
        checkResetState("reset_released");

        // Fill the whole program with ordinary words.
        for (int i = 0; i < 16; i++) loadWord(4'(i), makeWord(3'($urandom_range(5))), 1'b1);

        // Three-word program ending in HALT, always ready.
        loadWord(4'd0, makeWord(3'b001), 1'b1);
        loadWord(4'd1, makeWord(3'b010), 1'b1);
        loadWord(4'd2, makeWord(3'b111), 1'b1);
        startRun();
        runProgram(10, 100, 2, 50, 1'b1, t);
        checkOutput("basic_count", 32'(instrCount), 2);
        checkOutput("basic_pc", 32'(pc), 2);

        // Stall in ISSUE for 5 cycles, then a write attempt while busy.
        loadWord(4'd0, makeWord(3'b011), 1'b1);
        loadWord(4'd1, makeWord(3'b000), 1'b1);
        loadWord(4'd2, makeWord(3'b111), 1'b1);
        startRun();
        runProgram(1, 0, 2, 6, 1'b0, t);
        loadWord(4'd1, makeWord(3'b101), 1'b0);
        checkOutput("busy_load_valid", 32'(issueValid), 1);
        checkOutput("busy_load_pc", 32'(pc), 0);
        doReset();
        checkResetState("after_stall_reset");
        startRun();
        runProgram(10, 100, 2, 50, 1'b1, t);

        // Asynchronous reset in the middle of ISSUE, then rerun.
        startRun();
        tick();
        checkOutput("pre_reset_valid", 32'(issueValid), 1);
        #3 rst = 1'b1;
        #1;
        checkResetState("mid_issue_reset");
        tick();
        rst = 1'b0;
        tick();
        startRun();
        runProgram(10, 70, 2, 100, 1'b1, t);
        checkOutput("rerun_count", 32'(instrCount), 2);

        // BRZ to addr 5, taken and not taken.
        loadWord(4'd0, {3'b110, 4'($urandom), 4'($urandom), 4'd5, 1'b0}, 1'b1);
        loadWord(4'd1, makeWord(3'b111), 1'b1);
        loadWord(4'd5, makeWord(3'b111), 1'b1);
        startRun();
        runProgram(10, 100, 1, 50, 1'b1, t);
        checkOutput("brz_taken_pc", 32'(pc), 5);
        startRun();
        runProgram(10, 100, 0, 50, 1'b1, t);
        checkOutput("brz_fallthrough_pc", 32'(pc), 1);

        // 16 ordinary words: 17 transfers wraps pc back to word 0.
        for (int i = 0; i < 16; i++) loadWord(4'(i), makeWord(3'($urandom_range(5))), 1'b1);
        startRun();
        runProgram(17, 100, 2, 100, 1'b0, t);
        checkOutput("wrap_count", 32'(instrCount), 17);
        checkOutput("wrap_pc", 32'(pc), 1);
        doReset();

        // 300 transfers with branches and random stalls saturate the count.
        for (int i = 0; i < 16; i++) loadWord(4'(i), makeWord(3'($urandom_range(6))), 1'b1);
        startRun();
        runProgram(300, 60, 2, 5000, 1'b0, t);
        checkOutput("saturated_count", 32'(instrCount), 255);
        doReset();

        // Random programs, each started with a coincident load of word 0.
        for (int r = 0; r < 4; r++) begin
            for (int i = 1; i < 16; i++) loadWord(4'(i), makeWord(3'($urandom_range(7))), 1'b1);
            w = makeWord(3'($urandom_range(7)));
            applyStimulus(1'b1, 4'd0, w, 1'b1, 1'b0);
            modelMem[0] = w;
            modelPc     = 0;
            modelCount  = 0;
            runProgram(40, 50, 2, 400, 1'b0, t);
            doReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
